regfile_scoreboard: RTL and testbench

- Architectural register file and hazard scoreboard: the receiving end of the writeback stage's rd/we/rdValue write interface.
- Accepts source-operand read requests from decode over a valid/ready handshake and returns registered operand values one cycle later.
- Tracks in-flight destination registers and stalls requests with RAW/WAW hazards until the matching writeback arrives.
- x0 is hardwired to zero.

---
 rtl/regfile_scoreboard.sv | 128 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Architectural register file with a RAW/WAW hazard scoreboard.
// Operand reads go over a valid/ready handshake and return one cycle later; writeback lands unconditionally.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic                     clk,
    input  logic                     rstf,
    input  logic                     t_req_valid,
    output logic                     t_req_ready,
    input  logic [$clog2(NREGS)-1:0] t_rs1,
    input  logic [$clog2(NREGS)-1:0] t_rs2,
    input  logic [$clog2(NREGS)-1:0] t_rd,
    input  logic                     t_rd_en,
    output logic                     i_rsp_valid,
    input  logic                     i_rsp_ready,
    output logic [XLEN-1:0]          i_rs1Value,
    output logic [XLEN-1:0]          i_rs2Value,
    input  logic                     wb_we,
    input  logic [$clog2(NREGS)-1:0] wb_rd,
    input  logic [XLEN-1:0]          wb_rdValue,
    output logic [NREGS-1:0]         busy,
    output logic [31:0]              stall_count
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_rspValid;
    logic [XLEN-1:0]  r_rs1Value;
    logic [XLEN-1:0]  r_rs2Value;
    logic [31:0]      r_stallCount;

    logic [NREGS-1:0] w_clr;
    logic [NREGS-1:0] w_set;
    logic [XLEN-1:0]  w_rs1Val;
    logic [XLEN-1:0]  w_rs2Val;
    logic             w_hazard;
    logic             w_ready;
    logic             w_accept;

    // Writeback to a non-zero register clears its busy bit and feeds the bypass.
    always_comb begin
        w_clr = '0;
        if (wb_we && wb_rd != '0)
            w_clr[wb_rd] = 1'b1;
    end

    always_comb begin
        w_rs1Val = '0;
        w_rs2Val = '0;
        if (t_rs1 != '0)
            w_rs1Val = w_clr[t_rs1] ? wb_rdValue : r_regs[t_rs1];
        if (t_rs2 != '0)
            w_rs2Val = w_clr[t_rs2] ? wb_rdValue : r_regs[t_rs2];
    end

    // A writeback arriving this cycle resolves the hazard, so the request can go straight through.
    always_comb begin
        w_hazard = 1'b0;
        if (t_rs1 != '0 && r_busy[t_rs1] && !w_clr[t_rs1])
            w_hazard = 1'b1;
        if (t_rs2 != '0 && r_busy[t_rs2] && !w_clr[t_rs2])
            w_hazard = 1'b1;
        if (t_rd_en && t_rd != '0 && r_busy[t_rd] && !w_clr[t_rd])
            w_hazard = 1'b1;
    end

    assign w_ready  = (!r_rspValid || i_rsp_ready) && !w_hazard;
    assign w_accept = t_req_valid && w_ready;

    always_comb begin
        w_set = '0;
        if (w_accept && t_rd_en && t_rd != '0)
            w_set[t_rd] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rstf) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= '0;
        end else if (wb_we && wb_rd != '0) begin
            r_regs[wb_rd] <= wb_rdValue;
        end
    end

    // The newly accepted writer is younger than the one writing back, so set beats clear.
    always_ff @(posedge clk) begin
        if (rstf)
            r_busy <= '0;
        else
            r_busy <= ((r_busy & ~w_clr) | w_set) & ~NREGS'(1);
    end

    always_ff @(posedge clk) begin
        if (rstf) begin
            r_rspValid <= 1'b0;
            r_rs1Value <= '0;
            r_rs2Value <= '0;
        end else if (w_accept) begin
            r_rspValid <= 1'b1;
            r_rs1Value <= w_rs1Val;
            r_rs2Value <= w_rs2Val;
        end else if (i_rsp_ready) begin
            r_rspValid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rstf)
            r_stallCount <= '0;
        else if (t_req_valid && !w_ready && r_stallCount != 32'hFFFF_FFFF)
            r_stallCount <= r_stallCount + 32'd1;
    end

    assign t_req_ready = w_ready;
    assign i_rsp_valid = r_rspValid;
    assign i_rs1Value  = r_rs1Value;
    assign i_rs2Value  = r_rs2Value;
    assign busy        = r_busy;
    assign stall_count = r_stallCount;

    // AW is kept for readers sizing external index buses.
    logic [AW-1:0] w_unusedAw;
    assign w_unusedAw = '0;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench: directed scenarios followed by random traffic, all compared against a behavioural model.
module tb_regfile_scoreboard;

    logic        clk;
    logic        rstf;
    logic        t_req_valid;
    logic        t_req_ready;
    logic [4:0]  t_rs1;
    logic [4:0]  t_rs2;
    logic [4:0]  t_rd;
    logic        t_rd_en;
    logic        i_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] i_rs1Value;
    logic [31:0] i_rs2Value;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rdValue;
    logic [31:0] busy;
    logic [31:0] stall_count;

    regfile_scoreboard #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rstf(rstf),
        .t_req_valid(t_req_valid), .t_req_ready(t_req_ready),
        .t_rs1(t_rs1), .t_rs2(t_rs2), .t_rd(t_rd), .t_rd_en(t_rd_en),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .i_rs1Value(i_rs1Value), .i_rs2Value(i_rs2Value),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_rdValue(wb_rdValue),
        .busy(busy), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Behavioural model: architectural state as plain arrays
    logic [31:0] mRegs [32];
    bit          mBusy [32];
    bit          mRspValid;
    logic [31:0] mRsp1;
    logic [31:0] mRsp2;
    longint      mStall;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit rst, input bit v, input int rs1, input int rs2, input int rd,
                                 input bit rdEn, input bit rspRdy, input bit we, input int wrd,
                                 input logic [31:0] wval);
        rstf        = rst;
        t_req_valid = v;
        t_rs1       = 5'(rs1);
        t_rs2       = 5'(rs2);
        t_rd        = 5'(rd);
        t_rd_en     = rdEn;
        i_rsp_ready = rspRdy;
        wb_we       = we;
        wb_rd       = 5'(wrd);
        wb_rdValue  = wval;
    endtask

    function automatic logic [31:0] modelRead(input int r);
        if (r == 0) return 32'h0;
        if (wb_we && int'(wb_rd) == r) return wb_rdValue;
        return mRegs[r];
    endfunction

    function automatic bit stillBusy(input int r);
        return r != 0 && mBusy[r] && !(wb_we && int'(wb_rd) == r);
    endfunction

    // Compare all outputs with the model, then advance DUT and model by one clock.
    task automatic cycle();
        bit          expReady;
        bit          accept;
        logic [31:0] expBusy;
        logic [31:0] r1;
        logic [31:0] r2;
        #1;
        expReady = (!mRspValid || i_rsp_ready) && !stillBusy(int'(t_rs1)) && !stillBusy(int'(t_rs2))
                   && !(t_rd_en && stillBusy(int'(t_rd)));
        expBusy = '0;
        for (int i = 0; i < 32; i++) expBusy[i] = mBusy[i];
        checkOutput("ready", {31'b0, t_req_ready}, {31'b0, expReady});
        checkOutput("rspValid", {31'b0, i_rsp_valid}, {31'b0, mRspValid});
        if (mRspValid) begin
            checkOutput("rs1Value", i_rs1Value, mRsp1);
            checkOutput("rs2Value", i_rs2Value, mRsp2);
        end
        checkOutput("busy", busy, expBusy);
        checkOutput("stallCount", stall_count, 32'(mStall));
        accept = t_req_valid && expReady;
        r1 = modelRead(int'(t_rs1));
        r2 = modelRead(int'(t_rs2));
        @(posedge clk);
        if (rstf) begin
            for (int i = 0; i < 32; i++) begin
                mRegs[i] = '0;
                mBusy[i] = 1'b0;
            end
            mRspValid = 1'b0;
            mRsp1 = '0;
            mRsp2 = '0;
            mStall = 0;
        end else begin
            if (t_req_valid && !expReady && mStall < 64'hFFFF_FFFF) mStall++;
            if (accept) begin
                mRspValid = 1'b1;
                mRsp1 = r1;
                mRsp2 = r2;
            end else if (i_rsp_ready) begin
                mRspValid = 1'b0;
            end
            if (wb_we && wb_rd != 0) begin
                mRegs[wb_rd] = wb_rdValue;
                mBusy[wb_rd] = 1'b0;
            end
            if (accept && t_rd_en && t_rd != 0) mBusy[t_rd] = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input bit rspRdy);
        applyStimulus(0, 0, 0, 0, 0, 0, rspRdy, 0, 0, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            mRegs[i] = 'x;
            mBusy[i] = 1'b0;
        end
        mRspValid = 1'b0;
        mRsp1 = '0;
        mRsp2 = '0;
        mStall = 0;
        applyStimulus(1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h0);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        // Model now mirrors the reset state; the DUT has already seen one reset edge.
        for (int i = 0; i < 32; i++) mRegs[i] = '0;
        cycle();
        checkOutput("reset busy", busy, 32'h0);
        checkOutput("reset rspValid", {31'b0, i_rsp_valid}, 32'h0);

        // Write x5 then read it back alongside x0
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 5, 32'h1234_5678); cycle();
        applyStimulus(0, 1, 5, 0, 0, 0, 1, 0, 0, 32'h0);          cycle();
        idle(1);
        checkOutput("x5 rsp valid", {31'b0, i_rsp_valid}, 32'h1);
        checkOutput("x5 value", i_rs1Value, 32'h1234_5678);
        checkOutput("x5 rs2 zero", i_rs2Value, 32'h0);
        cycle();

        // Writes to x0 are dropped
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 0, 32'hFFFF_FFFF); cycle();
        applyStimulus(0, 1, 0, 0, 0, 1, 1, 0, 0, 32'h0);          cycle();
        idle(1);
        checkOutput("x0 value", i_rs1Value, 32'h0);
        checkOutput("x0 never busy", {31'b0, busy[0]}, 32'h0);
        cycle();

        // RAW stall on x7 resolved by a bypassed writeback
        applyStimulus(0, 1, 0, 0, 7, 1, 1, 0, 0, 32'h0); cycle();
        applyStimulus(0, 1, 7, 0, 0, 0, 1, 0, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            #1 checkOutput("raw x7 stalled", {31'b0, t_req_ready}, 32'h0);
            cycle();
        end
        checkOutput("stall count 3", stall_count, 32'd3);
        applyStimulus(0, 1, 7, 0, 0, 0, 1, 1, 7, 32'hA5A5_A5A5);
        #1 checkOutput("raw x7 released", {31'b0, t_req_ready}, 32'h1);
        cycle();
        idle(1);
        checkOutput("x7 bypass", i_rs1Value, 32'hA5A5_A5A5);
        checkOutput("x7 cleared", {31'b0, busy[7]}, 32'h0);
        cycle();

        // Set beats clear on x3
        applyStimulus(0, 1, 0, 0, 3, 1, 1, 1, 3, 32'h0000_0033); cycle();
        checkOutput("x3 set wins", {31'b0, busy[3]}, 32'h1);
        applyStimulus(0, 1, 3, 0, 0, 0, 1, 0, 0, 32'h0); cycle(); cycle();
        applyStimulus(0, 1, 3, 0, 0, 0, 1, 1, 3, 32'h0000_0333); cycle();
        idle(1);
        checkOutput("x3 bypass", i_rs1Value, 32'h0000_0333);
        cycle();

        // Back-pressure holds the response, then back-to-back accept
        applyStimulus(0, 1, 5, 3, 0, 0, 0, 0, 0, 32'h0); cycle();
        applyStimulus(0, 1, 3, 5, 0, 0, 0, 1, 5, 32'hDEAD_BEEF);
        for (int i = 0; i < 3; i++) cycle();
        checkOutput("held rs1", i_rs1Value, 32'h1234_5678);
        applyStimulus(0, 1, 3, 5, 0, 0, 1, 0, 0, 32'h0); cycle();
        idle(1);
        checkOutput("b2b rs2", i_rs2Value, 32'hDEAD_BEEF);
        cycle();

        // Reset with x9 busy and a response pending
        applyStimulus(0, 1, 0, 0, 9, 1, 0, 0, 0, 32'h0); cycle();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 9, 32'h9999_9999); cycle();
        checkOutput("post reset busy", busy, 32'h0);
        checkOutput("post reset stall", stall_count, 32'h0);
        applyStimulus(0, 1, 9, 0, 0, 0, 1, 0, 0, 32'h0); cycle();
        idle(1);
        checkOutput("x9 after reset", i_rs1Value, 32'h0);
        cycle();

        // Random traffic on a small register window to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                          int'($urandom_range(0, 7)), $urandom_range(0, 2) == 0,
                          $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                          int'($urandom_range(0, 7)), $urandom);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
